// File: rtl/agc_level_detector_pkg.sv
// Shared definitions for the AGC level detector: FSM state encoding and
// the gain-array width that bounds the number of search steps.
package agc_level_detector_pkg;

  localparam int AGC_GAIN_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_LOCKED  = 3'd5
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_SETTLE) || (s == ST_MEASURE) || (s == ST_DECIDE) || (s == ST_ISSUE);
  endfunction

endpackage

// File: rtl/agc_level_detector_if.sv
// Sample/command bundle between the AGC level detector and its system side.
interface agc_level_detector_if #(parameter int DATA_W = 8);

  logic                     start;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample;
  logic                     search_done;
  logic                     adjust;
  logic                     up_dn;
  logic                     busy;
  logic                     locked;
  logic        [DATA_W-2:0] peak;

  modport master (
    output start, sample_valid, sample, search_done,
    input  adjust, up_dn, busy, locked, peak
  );

  modport slave (
    input  start, sample_valid, sample, search_done,
    output adjust, up_dn, busy, locked, peak
  );

endinterface

// File: rtl/agc_level_detector_peak_abs.sv
// Saturating magnitude of a signed sample feeding a clearable peak-hold register.
module agc_level_detector_peak_abs #(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  output logic        [DATA_W-2:0] hold
);

  localparam int MAG_W = DATA_W - 1;

  // The most negative code has no positive twin; clamp it to full scale.
  function automatic logic [MAG_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (x == {1'b1, {MAG_W{1'b0}}}) return {MAG_W{1'b1}};
    else if (x[DATA_W-1])            return neg[MAG_W-1:0];
    else                             return x[MAG_W-1:0];
  endfunction

  logic [MAG_W-1:0] mag;

  assign mag = sat_abs(sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (clr) begin
      hold <= '0;
    end else if (en && (mag > hold)) begin
      hold <= mag;
    end
  end

endmodule

// File: rtl/agc_level_detector.sv
// Command side of the AGC binary search: measures windowed peak magnitude,
// compares it with TARGET and issues one up/down adjust pulse per decision.
module agc_level_detector
  import agc_level_detector_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int WIN_LEN    = 64,
  parameter int SETTLE_CYC = 16,
  parameter int TARGET     = 64,
  parameter int MAX_STEPS  = AGC_GAIN_W
) (
  input  logic                 clk,
  input  logic                 RESETn,
  agc_level_detector_if.slave  bus
);

  localparam int MAG_W  = DATA_W - 1;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  state_t              state, state_nxt;
  logic [SET_W-1:0]    settle_cnt, settle_nxt;
  logic [WIN_W-1:0]    win_cnt, win_nxt;
  logic [STEP_W-1:0]   step_cnt, step_nxt;
  logic                adjust_q, adjust_nxt;
  logic                up_dn_q, up_dn_nxt;
  logic [MAG_W-1:0]    peak_q, peak_nxt;
  logic                hold_clr, hold_en;
  logic [MAG_W-1:0]    hold;

  agc_level_detector_peak_abs #(.DATA_W(DATA_W)) u_peak (
    .clk    (clk),
    .rst_n  (RESETn),
    .clr    (hold_clr),
    .en     (hold_en),
    .sample (bus.sample),
    .hold   (hold)
  );

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    win_nxt    = win_cnt;
    step_nxt   = step_cnt;
    adjust_nxt = 1'b0;
    up_dn_nxt  = up_dn_q;
    peak_nxt   = peak_q;
    hold_clr   = 1'b0;
    hold_en    = 1'b0;
    unique case (state)
      ST_IDLE, ST_LOCKED: begin
        if (bus.start) begin
          state_nxt  = ST_SETTLE;
          step_nxt   = '0;
          settle_nxt = '0;
        end
      end
      ST_SETTLE: begin
        // Lock check runs every settling cycle; done lands one cycle after adjust.
        if (bus.search_done || (step_cnt == STEP_W'(MAX_STEPS))) begin
          state_nxt = ST_LOCKED;
        end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
          state_nxt = ST_MEASURE;
          win_nxt   = '0;
          hold_clr  = 1'b1;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (bus.sample_valid) begin
          hold_en = 1'b1;
          win_nxt = win_cnt + 1'b1;
          if (win_cnt == WIN_W'(WIN_LEN - 1)) state_nxt = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        peak_nxt   = hold;
        up_dn_nxt  = (hold < MAG_W'(TARGET));
        adjust_nxt = 1'b1;
        state_nxt  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (step_cnt != STEP_W'(MAX_STEPS)) step_nxt = step_cnt + 1'b1;
        settle_nxt = '0;
        state_nxt  = ST_SETTLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      step_cnt   <= '0;
      adjust_q   <= 1'b0;
      up_dn_q    <= 1'b0;
      peak_q     <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      win_cnt    <= win_nxt;
      step_cnt   <= step_nxt;
      adjust_q   <= adjust_nxt;
      up_dn_q    <= up_dn_nxt;
      peak_q     <= peak_nxt;
    end
  end

  assign bus.adjust = adjust_q;
  assign bus.up_dn  = up_dn_q;
  assign bus.peak   = peak_q;
  assign bus.busy   = is_busy(state);
  assign bus.locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_agc_level_detector.sv
// Randomized scenario bench for agc_level_detector against a window-level
// behavioural model (peak of saturated magnitudes, threshold, fixed latency).
module tb_agc_level_detector;

  localparam int DATA_W     = 8;
  localparam int WIN_LEN    = 4;
  localparam int SETTLE_CYC = 2;
  localparam int TARGET     = 64;
  localparam int MAX_STEPS  = 6;

  logic clk = 1'b0;
  logic RESETn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   adj_cnt = 0;
  logic signed [DATA_W-1:0] win_buf [WIN_LEN];

  agc_level_detector_if #(.DATA_W(DATA_W)) ifc ();

  agc_level_detector #(
    .DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .SETTLE_CYC(SETTLE_CYC),
    .TARGET(TARGET), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk    (clk),
    .RESETn (RESETn),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ifc.adjust === 1'b1) adj_cnt = adj_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: magnitude with the most negative code clamped to full scale.
  function automatic int ref_mag(input logic signed [DATA_W-1:0] s);
    int v;
    v = s;
    if (v < 0) v = -v;
    if (v > 127) v = 127;
    return v;
  endfunction

  function automatic int ref_peak();
    int m;
    m = 0;
    for (int i = 0; i < WIN_LEN; i++) if (ref_mag(win_buf[i]) > m) m = ref_mag(win_buf[i]);
    return m;
  endfunction

  task automatic do_reset();
    RESETn = 1'b0;
    ifc.start = 1'b0; ifc.sample_valid = 1'b0; ifc.sample = '0; ifc.search_done = 1'b0;
    tick(); tick();
    RESETn = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  // Entered on the first settling cycle; leaves on the first settling cycle after ISSUE.
  task automatic run_window(input int gap, input bit start_mid,
                            output logic a1, output logic a2, output logic a3,
                            output logic ud, output logic bz, output logic [DATA_W-2:0] pk);
    for (int i = 0; i < SETTLE_CYC; i++) begin
      ifc.sample_valid = 1'b1; ifc.sample = 8'sd127; tick();
    end
    for (int i = 0; i < WIN_LEN; i++) begin
      for (int g = 0; g < gap; g++) begin
        ifc.sample_valid = 1'b0; ifc.sample = 8'sd127; tick();
      end
      ifc.sample_valid = 1'b1; ifc.sample = win_buf[i];
      ifc.start = start_mid && (i == 1);
      tick();
      ifc.start = 1'b0;
    end
    ifc.sample_valid = 1'b0; ifc.sample = '0;
    a1 = ifc.adjust; tick();
    a2 = ifc.adjust; ud = ifc.up_dn; pk = ifc.peak; bz = ifc.busy; tick();
    a3 = ifc.adjust;
  endtask

  task automatic test_reset();
    logic a1, a2, a3, ud, bz;
    logic [DATA_W-2:0] pk;
    ifc.start = 1'b0; ifc.sample_valid = 1'b0; ifc.sample = '0; ifc.search_done = 1'b0;
    RESETn = 1'b0;
    tick(); tick();
    vectors++; if (ifc.adjust !== 1'b0) begin miscompares++; $display("FAIL reset_adjust: got %b expected 0", ifc.adjust); end
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
    vectors++; if (ifc.locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", ifc.locked); end
    vectors++; if (ifc.peak !== 7'd0) begin miscompares++; $display("FAIL reset_peak: got %0d expected 0", ifc.peak); end
    RESETn = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'sd10;
    run_window(0, 1'b0, a1, a2, a3, ud, bz, pk);
    vectors++; if (pk !== 7'(ref_peak())) begin miscompares++; $display("FAIL pre_reset_peak: got %0d expected %0d", pk, ref_peak()); end
    // Settle, then two window samples: reset strikes mid-measurement.
    for (int i = 0; i < SETTLE_CYC + 2; i++) begin
      ifc.sample_valid = 1'b1; ifc.sample = 8'sd20; tick();
    end
    RESETn = 1'b0;
    #1;
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", ifc.busy); end
    vectors++; if (ifc.up_dn !== 1'b0) begin miscompares++; $display("FAIL midreset_up_dn: got %b expected 0", ifc.up_dn); end
    vectors++; if (ifc.peak !== 7'd0) begin miscompares++; $display("FAIL midreset_peak: got %0d expected 0", ifc.peak); end
    tick();
    RESETn = 1'b1;
    adj_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      ifc.sample_valid = 1'b1; ifc.sample = 8'($urandom_range(0, 255)); tick();
    end
    ifc.sample_valid = 1'b0;
    vectors++; if (adj_cnt !== 0) begin miscompares++; $display("FAIL no_start_adjusts: got %0d expected 0", adj_cnt); end
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL no_start_busy: got %b expected 0", ifc.busy); end
    // Cancel an adjust that is already on the output.
    pulse_start();
    for (int i = 0; i < SETTLE_CYC + WIN_LEN; i++) begin
      ifc.sample_valid = 1'b1; ifc.sample = 8'sd5; tick();
    end
    ifc.sample_valid = 1'b0;
    tick();
    vectors++; if (ifc.adjust !== 1'b1) begin miscompares++; $display("FAIL inflight_adjust_seen: got %b expected 1", ifc.adjust); end
    RESETn = 1'b0;
    #1;
    vectors++; if (ifc.adjust !== 1'b0) begin miscompares++; $display("FAIL inflight_adjust_cancel: got %b expected 0", ifc.adjust); end
    tick();
    RESETn = 1'b1;
    tick();
  endtask

  task automatic test_constant();
    logic a1, a2, a3, ud, bz;
    logic [DATA_W-2:0] pk;
    adj_cnt = 0;
    pulse_start();
    for (int k = 0; k < MAX_STEPS; k++) begin
      for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'sd10;
      run_window(0, 1'b0, a1, a2, a3, ud, bz, pk);
      vectors++; if ({a1, a2, a3} !== 3'b010) begin miscompares++; $display("FAIL const_pulse_shape[%0d]: got %b expected 010", k, {a1, a2, a3}); end
      vectors++; if (ud !== 1'b1) begin miscompares++; $display("FAIL const_up_dn[%0d]: got %b expected 1", k, ud); end
      vectors++; if (pk !== 7'(ref_peak())) begin miscompares++; $display("FAIL const_peak[%0d]: got %0d expected %0d", k, pk, ref_peak()); end
      vectors++; if (bz !== 1'b1) begin miscompares++; $display("FAIL const_busy[%0d]: got %b expected 1", k, bz); end
    end
    tick();
    vectors++; if (ifc.locked !== 1'b1) begin miscompares++; $display("FAIL const_locked: got %b expected 1", ifc.locked); end
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL const_idle_busy: got %b expected 0", ifc.busy); end
    for (int i = 0; i < 20; i++) begin
      ifc.sample_valid = 1'b1; ifc.sample = 8'sd10; tick();
    end
    ifc.sample_valid = 1'b0;
    vectors++; if (adj_cnt !== MAX_STEPS) begin miscompares++; $display("FAIL const_total_adjusts: got %0d expected %0d", adj_cnt, MAX_STEPS); end
    vectors++; if (ifc.locked !== 1'b1) begin miscompares++; $display("FAIL const_lock_held: got %b expected 1", ifc.locked); end
  endtask

  task automatic test_saturation_and_tie();
    logic a1, a2, a3, ud, bz;
    logic [DATA_W-2:0] pk;
    int pos;
    pulse_start();
    for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'($urandom_range(0, 255));
    pos = $urandom_range(0, WIN_LEN - 1);
    win_buf[pos] = -8'sd128;
    run_window(0, 1'b0, a1, a2, a3, ud, bz, pk);
    vectors++; if (pk !== 7'(ref_peak()) || pk !== 7'd127) begin miscompares++; $display("FAIL sat_peak: got %0d expected %0d", pk, ref_peak()); end
    vectors++; if (ud !== 1'b0) begin miscompares++; $display("FAIL sat_up_dn: got %b expected 0", ud); end
    for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'(int'($urandom_range(0, 127)) - 64);
    pos = $urandom_range(0, WIN_LEN - 1);
    win_buf[pos] = -8'sd64;
    run_window(0, 1'b0, a1, a2, a3, ud, bz, pk);
    vectors++; if (pk !== 7'(ref_peak())) begin miscompares++; $display("FAIL tie_peak: got %0d expected %0d", pk, ref_peak()); end
    vectors++; if (ud !== (ref_peak() < TARGET) || ud !== 1'b0) begin miscompares++; $display("FAIL tie_up_dn: got %b expected 0", ud); end
    do_reset();
  endtask

  task automatic test_below_target_gapped();
    logic a1, a2, a3, ud, bz;
    logic [DATA_W-2:0] pk;
    int pos;
    pulse_start();
    for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'(int'($urandom_range(0, 126)) - 63);
    pos = $urandom_range(0, WIN_LEN - 1);
    win_buf[pos] = 8'sd63;
    run_window(2, 1'b0, a1, a2, a3, ud, bz, pk);
    vectors++; if ({a1, a2, a3} !== 3'b010) begin miscompares++; $display("FAIL gap_pulse_shape: got %b expected 010", {a1, a2, a3}); end
    vectors++; if (pk !== 7'(ref_peak())) begin miscompares++; $display("FAIL gap_peak: got %0d expected %0d", pk, ref_peak()); end
    vectors++; if (ud !== 1'b1) begin miscompares++; $display("FAIL gap_up_dn: got %b expected 1", ud); end
    do_reset();
  endtask

  task automatic test_search_done();
    logic a1, a2, a3, ud, bz;
    logic [DATA_W-2:0] pk;
    adj_cnt = 0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'($urandom_range(0, 255));
      run_window(0, 1'b0, a1, a2, a3, ud, bz, pk);
    end
    ifc.search_done = 1'b1;
    tick();
    ifc.search_done = 1'b0;
    vectors++; if (ifc.locked !== 1'b1) begin miscompares++; $display("FAIL done_locked: got %b expected 1", ifc.locked); end
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL done_busy: got %b expected 0", ifc.busy); end
    vectors++; if (int'(dut.step_cnt) !== 3) begin miscompares++; $display("FAIL done_step_cnt: got %0d expected 3", dut.step_cnt); end
    for (int i = 0; i < 20; i++) begin
      ifc.sample_valid = 1'b1; ifc.sample = 8'sd1; tick();
    end
    ifc.sample_valid = 1'b0;
    vectors++; if (adj_cnt !== 3) begin miscompares++; $display("FAIL done_total_adjusts: got %0d expected 3", adj_cnt); end
  endtask

  task automatic test_start_handling();
    logic a1, a2, a3, ud, bz;
    logic [DATA_W-2:0] pk;
    pulse_start();
    vectors++; if (ifc.locked !== 1'b0) begin miscompares++; $display("FAIL restart_locked: got %b expected 0", ifc.locked); end
    vectors++; if (ifc.busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b expected 1", ifc.busy); end
    for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'($urandom_range(0, 255));
    run_window(0, 1'b1, a1, a2, a3, ud, bz, pk);
    vectors++; if ({a1, a2, a3} !== 3'b010) begin miscompares++; $display("FAIL busy_start_ignored: got %b expected 010", {a1, a2, a3}); end
    vectors++; if (pk !== 7'(ref_peak())) begin miscompares++; $display("FAIL busy_start_peak: got %0d expected %0d", pk, ref_peak()); end
  endtask

  task automatic test_random_search();
    logic a1, a2, a3, ud, bz;
    logic [DATA_W-2:0] pk;
    int gap;
    do_reset();
    adj_cnt = 0;
    pulse_start();
    for (int k = 0; k < MAX_STEPS; k++) begin
      for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 2);
      run_window(gap, 1'b0, a1, a2, a3, ud, bz, pk);
      vectors++; if ({a1, a2, a3} !== 3'b010) begin miscompares++; $display("FAIL rnd_pulse_shape[%0d]: got %b expected 010", k, {a1, a2, a3}); end
      vectors++; if (pk !== 7'(ref_peak())) begin miscompares++; $display("FAIL rnd_peak[%0d]: got %0d expected %0d", k, pk, ref_peak()); end
      vectors++; if (ud !== (ref_peak() < TARGET)) begin miscompares++; $display("FAIL rnd_up_dn[%0d]: got %b expected %b", k, ud, ref_peak() < TARGET); end
    end
    tick();
    vectors++; if (ifc.locked !== 1'b1) begin miscompares++; $display("FAIL rnd_locked: got %b expected 1", ifc.locked); end
    vectors++; if (adj_cnt !== MAX_STEPS) begin miscompares++; $display("FAIL rnd_total_adjusts: got %0d expected %0d", adj_cnt, MAX_STEPS); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_saturation_and_tie();
    test_below_target_gapped();
    test_search_done();
    test_start_handling();
    test_random_search();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
